// File: rtl/fir_uart_sequencer_if.sv
// Stream-path bus between the UART receiver/transmitter, the FIR filter and the sequencer.
// The sequencer takes the master view; the surrounding environment takes the slave view.
interface fir_uart_sequencer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 38,
    parameter int OFIFO_LOG = 2
);
    logic                 rx_ready;
    logic [7:0]           rx_data;
    logic                 fir_in_valid;
    logic [IN_WIDTH-1:0]  fir_in;
    logic                 fir_out_valid;
    logic [OUT_WIDTH-1:0] fir_out;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 overrun;
    logic                 clear_err;
    logic [OFIFO_LOG:0]   ofifo_level;

    modport master (
        input  rx_ready, rx_data, fir_out_valid, fir_out, tx_busy, clear_err,
        output fir_in_valid, fir_in, tx_start, tx_data, overrun, ofifo_level
    );

    modport slave (
        output rx_ready, rx_data, fir_out_valid, fir_out, tx_busy, clear_err,
        input  fir_in_valid, fir_in, tx_start, tx_data, overrun, ofifo_level
    );
endinterface

// File: rtl/fir_uart_sequencer.sv
// UART -> FIR -> UART stream sequencer: pairs received bytes into FIR samples, buffers
// (optionally saturated) FIR results in a small FIFO and sends each one as two bytes.
module fir_uart_sequencer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 38,
    parameter int OUT_LSB   = 8,
    parameter int SAT       = 1,
    parameter int OFIFO_LOG = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_uart_sequencer_if.master bus
);
    localparam int DEPTH = 1 << OFIFO_LOG;
    localparam int TOP_W = OUT_WIDTH - OUT_LSB - 15;
    localparam logic [OFIFO_LOG:0] FULL_LVL = (OFIFO_LOG + 1)'(DEPTH);

    typedef enum logic {
        RX_LO,
        RX_HI
    } rx_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_LO,
        GUARD_LO,
        WAIT_LO,
        SEND_HI,
        GUARD_HI,
        WAIT_HI
    } tx_state_t;

    // Bits above the slice must all equal the slice sign bit, otherwise the result clips.
    function automatic logic signed [15:0] f_sat_slice(input logic signed [OUT_WIDTH-1:0] i_v);
        logic [TOP_W-1:0] w_top;
        w_top = i_v[OUT_WIDTH-1:OUT_LSB+15];
        if ((SAT != 0) && !((&w_top) || !(|w_top))) begin
            return i_v[OUT_WIDTH-1] ? 16'sh8000 : 16'sh7fff;
        end
        return $signed(i_v[OUT_LSB+15:OUT_LSB]);
    endfunction

    rx_state_t                   r_rx_state;
    rx_state_t                   w_rx_next;
    logic                        w_rx_word;
    logic [7:0]                  r_lo;
    logic [IN_WIDTH-1:0]         r_fir_in_p1;
    logic                        r_vld_p1;

    tx_state_t                   r_tx_state;
    tx_state_t                   w_tx_next;
    logic                        w_tx_start;
    logic [7:0]                  w_tx_data;

    logic signed [15:0]          r_mem [DEPTH];
    logic signed [15:0]          r_hold;
    logic signed [15:0]          w_slice;
    logic [OFIFO_LOG-1:0]        r_wr_ptr;
    logic [OFIFO_LOG-1:0]        r_rd_ptr;
    logic [OFIFO_LOG:0]          r_level;
    logic                        r_overrun;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_drop;

    // ---- receive side: low byte first, second byte completes the sample
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_word = 1'b0;
        case (r_rx_state)
            RX_LO: begin
                if (bus.rx_ready) begin
                    w_rx_next = RX_HI;
                end
            end
            RX_HI: begin
                if (bus.rx_ready) begin
                    w_rx_next = RX_LO;
                    w_rx_word = 1'b1;
                end
            end
            default: w_rx_next = RX_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= RX_LO;
            r_vld_p1    <= 1'b0;
            r_fir_in_p1 <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_vld_p1   <= w_rx_word;
            if (w_rx_word) begin
                r_fir_in_p1 <= {bus.rx_data, r_lo};
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_rx_state == RX_LO) && bus.rx_ready) begin
            r_lo <= bus.rx_data;
        end
    end

    // ---- result capture into the output FIFO
    assign w_slice = f_sat_slice($signed(bus.fir_out));
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    // A full FIFO still accepts a result when a word leaves on the same edge.
    assign w_push  = bus.fir_out_valid && (!w_full || w_pop);
    assign w_drop  = bus.fir_out_valid && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + OFIFO_LOG'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + OFIFO_LOG'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (OFIFO_LOG + 1)'(1);
                2'b01:   r_level <= r_level - (OFIFO_LOG + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // When full, write and read address coincide; the read still sees the old word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_slice;
        end
        if (w_pop) begin
            r_hold <= r_mem[r_rd_ptr];
        end
    end

    // ---- transmit side: two bytes per word, guard cycle covers tx_busy rise latency
    always_comb begin
        w_tx_next  = r_tx_state;
        w_pop      = 1'b0;
        w_tx_start = 1'b0;
        w_tx_data  = 8'h00;
        case (r_tx_state)
            IDLE: begin
                if (!w_empty && !bus.tx_busy) begin
                    w_pop     = 1'b1;
                    w_tx_next = SEND_LO;
                end
            end
            SEND_LO: begin
                w_tx_start = 1'b1;
                w_tx_data  = r_hold[7:0];
                w_tx_next  = GUARD_LO;
            end
            GUARD_LO: begin
                w_tx_data = r_hold[7:0];
                w_tx_next = WAIT_LO;
            end
            WAIT_LO: begin
                w_tx_data = r_hold[7:0];
                if (!bus.tx_busy) begin
                    w_tx_next = SEND_HI;
                end
            end
            SEND_HI: begin
                w_tx_start = 1'b1;
                w_tx_data  = r_hold[15:8];
                w_tx_next  = GUARD_HI;
            end
            GUARD_HI: begin
                w_tx_data = r_hold[15:8];
                w_tx_next = WAIT_HI;
            end
            WAIT_HI: begin
                w_tx_data = r_hold[15:8];
                if (!bus.tx_busy) begin
                    w_tx_next = IDLE;
                end
            end
            default: w_tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    assign bus.fir_in_valid = r_vld_p1;
    assign bus.fir_in       = r_fir_in_p1;
    assign bus.tx_start     = w_tx_start;
    assign bus.tx_data      = w_tx_data;
    assign bus.overrun      = r_overrun;
    assign bus.ofifo_level  = r_level;
endmodule
